// File: rtl/discrete_filter_sequencer.sv
// One shared signed multiplier, time-sliced across NCH first-order recurrences y = (A*y + B*x) >>> FRAC.
// Optional build macro DISCRETE_SEQ_SAT_EN: saturating result reduction plus a sticky sat_hit flag.
module discrete_filter_sequencer #(
    parameter int NCH  = 4,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = 14,
    localparam int AW  = $clog2(NCH) + 1
) (
    input  logic              clk,
    input  logic              I_RSTn,
    input  logic              audio_clk_en,
    input  logic [NCH*DW-1:0] x_in,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [CW-1:0]     cfg_data,
    input  logic              ovr_clr,
    output logic [NCH*DW-1:0] y_out,
    output logic              y_valid,
    output logic              busy,
`ifdef DISCRETE_SEQ_SAT_EN
    output logic              sat_hit,
`endif
    output logic              overrun
);
    localparam int PW  = DW + CW;
    localparam int SW  = PW + 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL_A = 3'd1;
    localparam logic [2:0] S_MUL_B = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                  fsm;
    logic [CHW-1:0]              ch;
    logic [NCH-1:0][CW-1:0]      sh_a, sh_b, act_a, act_b, sh_a_nxt, sh_b_nxt;
    logic [NCH-1:0][DW-1:0]      st, xs, y_nxt;
    logic signed [SW-1:0]        acc, shr;
    logic signed [CW-1:0]        m_c;
    logic signed [DW-1:0]        m_d;
    logic signed [PW-1:0]        prod;
    logic [DW-1:0]               r;
    int                          wr_ch;

    assign busy  = (fsm != S_IDLE);
    assign wr_ch = int'(cfg_addr >> 1);

    // Shadow-bank next value; the tick copy reads this so a same-cycle write passes straight through.
    always_comb begin
        sh_a_nxt = sh_a;
        sh_b_nxt = sh_b;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_we && wr_ch == i) begin
                if (cfg_addr[0]) sh_b_nxt[i] = cfg_data;
                else             sh_a_nxt[i] = cfg_data;
            end
        end
    end

    // The single multiplier: A*state in MUL_A, B*snapshot in MUL_B.
    always_comb begin
        if (fsm == S_MUL_B) begin
            m_c = act_b[ch];
            m_d = xs[ch];
        end else begin
            m_c = act_a[ch];
            m_d = st[ch];
        end
    end
    assign prod = m_c * m_d;
    assign shr  = acc >>> FRAC;

`ifdef DISCRETE_SEQ_SAT_EN
    logic [SW-DW:0] hi;
    logic           ovf;
    assign hi  = shr[SW-1:DW-1];
    assign ovf = !((&hi) || !(|hi));
    assign r   = ovf ? (shr[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                     : shr[DW-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^shr[SW-1:DW];
    assign r         = shr[DW-1:0];
`endif

    always_comb begin
        y_nxt     = st;
        y_nxt[ch] = r;
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            fsm     <= S_IDLE;
            ch      <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            act_a   <= '0;
            act_b   <= '0;
            st      <= '0;
            xs      <= '0;
            acc     <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
`ifdef DISCRETE_SEQ_SAT_EN
            sat_hit <= 1'b0;
`endif
        end else begin
            y_valid <= 1'b0;
            sh_a    <= sh_a_nxt;
            sh_b    <= sh_b_nxt;
            if (audio_clk_en && fsm != S_IDLE) overrun <= 1'b1;
            else if (ovr_clr)                  overrun <= 1'b0;
`ifdef DISCRETE_SEQ_SAT_EN
            if (fsm == S_WR && ovf) sat_hit <= 1'b1;
            else if (ovr_clr)       sat_hit <= 1'b0;
`endif
            case (fsm)
                S_IDLE: if (audio_clk_en) begin
                    act_a <= sh_a_nxt;
                    act_b <= sh_b_nxt;
                    xs    <= x_in;
                    ch    <= '0;
                    fsm   <= S_MUL_A;
                end
                S_MUL_A: begin
                    acc <= {prod[PW-1], prod};
                    fsm <= S_MUL_B;
                end
                S_MUL_B: begin
                    acc <= acc + {prod[PW-1], prod};
                    fsm <= S_WR;
                end
                S_WR: begin
                    st[ch] <= r;
                    if (ch == CHW'(NCH-1)) begin
                        // Publish on this edge so y_out and y_valid appear together in DONE.
                        y_out   <= y_nxt;
                        y_valid <= 1'b1;
                        fsm     <= S_DONE;
                    end else begin
                        ch  <= ch + 1'b1;
                        fsm <= S_MUL_A;
                    end
                end
                S_DONE:  fsm <= S_IDLE;
                default: fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_discrete_filter_sequencer.sv
// Directed bench for discrete_filter_sequencer: arithmetic model + per-cycle compare + literal checks.
module tb_discrete_filter_sequencer;
    localparam int NCH = 4, DW = 16, CW = 16, FRAC = 14;
    localparam int AW  = $clog2(NCH) + 1;
    localparam int LAT = 3*NCH + 1;

    logic clk = 0, I_RSTn = 0, audio_clk_en = 0, cfg_we = 0, ovr_clr = 0;
    logic [NCH*DW-1:0] x_in = '0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [CW-1:0]     cfg_data = '0;
    logic [NCH*DW-1:0] y_out;
    logic              y_valid, busy, overrun;
`ifdef DISCRETE_SEQ_SAT_EN
    logic              sat_hit;
`endif

    int total = 0, bad = 0;
    int cyc = 0, t0 = 0;

    always #5 clk = ~clk;

    discrete_filter_sequencer #(.NCH(NCH), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en), .x_in(x_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ovr_clr(ovr_clr),
        .y_out(y_out), .y_valid(y_valid), .busy(busy),
`ifdef DISCRETE_SEQ_SAT_EN
        .sat_hit(sat_hit),
`endif
        .overrun(overrun)
    );

    function automatic void chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic longint fit(input longint v, output bit s);
        longint lo = -(longint'(1) <<< (DW-1));
        longint hi = (longint'(1) <<< (DW-1)) - 1;
        s = 0;
`ifdef DISCRETE_SEQ_SAT_EN
        if (v > hi) begin s = 1; return hi; end
        if (v < lo) begin s = 1; return lo; end
        return v;
`else
        v = v & ((longint'(1) <<< DW) - 1);
        if (v > hi) v = v + 2*lo;
        return v;
`endif
    endfunction

    function automatic longint ych(int c);
        return longint'($signed(y_out[c*DW +: DW]));
    endfunction

    // Model: whole-sequence result computed at tick acceptance, released on the spec's timeline.
    longint sha[NCH], shb[NCH], mst[NCH], my[NCH], pend[NCH];
    bit     psat[NCH];
    bit     have_t = 0, m_ovr = 0, m_sat = 0, bnow, sov, ssat, sflag;
    int     t_acc = 0, widx;
    longint xv, v;

    initial forever begin
        @(posedge clk);
        if (!I_RSTn) begin
            for (int i = 0; i < NCH; i++) begin
                sha[i] = 0; shb[i] = 0; mst[i] = 0; my[i] = 0; pend[i] = 0; psat[i] = 0;
            end
            have_t = 0; m_ovr = 0; m_sat = 0;
        end else begin
            bnow = have_t && cyc >= t_acc + 1 && cyc <= t_acc + LAT;
            sov = 0; ssat = 0;
            if (cfg_we) begin
                widx = int'(cfg_addr >> 1);
                if (cfg_addr[0]) shb[widx] = longint'($signed(cfg_data));
                else             sha[widx] = longint'($signed(cfg_data));
            end
            if (have_t)
                for (int k = 0; k < NCH; k++)
                    if (cyc == t_acc + 3 + 3*k && psat[k]) ssat = 1;
            if (have_t && cyc == t_acc + 3*NCH)
                for (int i = 0; i < NCH; i++) my[i] = pend[i];
            if (audio_clk_en) begin
                if (bnow) sov = 1;
                else begin
                    have_t = 1; t_acc = cyc;
                    for (int i = 0; i < NCH; i++) begin
                        xv = longint'($signed(x_in[i*DW +: DW]));
                        v = (sha[i]*mst[i] + shb[i]*xv) >>> FRAC;
                        pend[i] = fit(v, sflag);
                        psat[i] = sflag;
                        mst[i] = pend[i];
                    end
                end
            end
            m_ovr = sov ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
            m_sat = ssat ? 1'b1 : (ovr_clr ? 1'b0 : m_sat);
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!I_RSTn) begin
            chk("cmp_valid_rst", y_valid, 0);
            chk("cmp_busy_rst", busy, 0);
            chk("cmp_ovr_rst", overrun, 0);
            for (int i = 0; i < NCH; i++) chk("cmp_y_rst", ych(i), 0);
        end else begin
            chk("cmp_valid", y_valid, (have_t && cyc == t_acc + LAT) ? 1 : 0);
            chk("cmp_busy", busy, (have_t && cyc >= t_acc + 1 && cyc <= t_acc + LAT) ? 1 : 0);
            chk("cmp_ovr", overrun, m_ovr);
`ifdef DISCRETE_SEQ_SAT_EN
            chk("cmp_sat", sat_hit, m_sat);
`endif
            for (int i = 0; i < NCH; i++) chk("cmp_y", ych(i), my[i]);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic cfg(int c, int sel, longint val);
        cfg_we = 1; cfg_addr = AW'(c*2 + sel); cfg_data = CW'(val);
        step();
        cfg_we = 0;
    endtask

    task automatic setx(int c, longint val);
        x_in[c*DW +: DW] = DW'(val);
    endtask

    task automatic tick();
        t0 = cyc; audio_clk_en = 1;
        step();
        audio_clk_en = 0;
    endtask

    task automatic wait_valid(string nm);
        int n = 0;
        while (!y_valid && n < 200) begin step(); n++; end
        if (!y_valid) chk({nm, "_timeout"}, 0, 1);
        else          chk({nm, "_lat"}, cyc - t0, LAT);
        step();
    endtask

    initial begin
        repeat (3) step();
        chk("rst_y0", ych(0), 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", y_valid, 0);
        chk("rst_ovr", overrun, 0);
        I_RSTn = 1;
        step();

        // 1: single channel, two ticks
        cfg(0, 0, 8192); cfg(0, 1, 8192); setx(0, 16384);
        tick(); wait_valid("t1a"); chk("t1a_y0", ych(0), 8192);
        tick(); wait_valid("t1b"); chk("t1b_y0", ych(0), 12288);

        // 2: four channels, mixed signs
        cfg(1, 0, -4096);  cfg(1, 1, 16384);
        cfg(2, 0, 12000);  cfg(2, 1, -3000);
        cfg(3, 0, -16384); cfg(3, 1, 20000);
        setx(1, 1000); setx(2, -20000); setx(3, 7777);
        repeat (3) begin tick(); wait_valid("t2"); end
        chk("t2_y1", ych(1), 812);
        chk("t2_y2", ych(2), 8308);
        chk("t2_y3", ych(3), 9493);

        // 3: tick while busy is dropped
        tick();
        repeat (4) step();
        audio_clk_en = 1; step(); audio_clk_en = 0;
        wait_valid("t3a");
        chk("t3_ovr", overrun, 1);
        ovr_clr = 1; step(); ovr_clr = 0;
        chk("t3_ovr_clr", overrun, 0);
        tick(); wait_valid("t3b");

        // 4: coefficient writes during busy and at the tick
        tick(); step(); cfg(0, 0, 16384); wait_valid("t4a");
        tick(); wait_valid("t4b");
        cfg_we = 1; cfg_addr = AW'(0); cfg_data = CW'(0);
        tick(); cfg_we = 0;
        wait_valid("t4c"); chk("t4c_y0", ych(0), 8192);

        // 5: result overflow
        cfg(0, 1, 32767); setx(0, 32767);
        tick(); wait_valid("t5");
`ifdef DISCRETE_SEQ_SAT_EN
        chk("t5_y0", ych(0), 32767);
        chk("t5_sat", sat_hit, 1);
        ovr_clr = 1; step(); ovr_clr = 0;
        chk("t5_sat_clr", sat_hit, 0);
`else
        chk("t5_y0", ych(0), -4);
`endif

        // 6: reset mid-sequence
        tick();
        repeat (5) step();
        I_RSTn = 0; #2;
        chk("t6_y0", ych(0), 0);
        chk("t6_busy", busy, 0);
        step(); step();
        I_RSTn = 1;
        repeat (20) step();
        cfg(0, 0, 8192); cfg(0, 1, 8192); setx(0, 16384);
        tick(); wait_valid("t6");
        chk("t6_y0_after", ych(0), 8192);
        chk("t6_y1_after", ych(1), 0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
